freq_meter: RTL

//   Measures the frequency of an external square wave against the 50 MHz system

---
 rtl/freq_meter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// window of clk_50m cycles. Each count is converted to 8-digit packed BCD with
// a serial double-dabble and published with a one-cycle valid pulse.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int MAX_COUNT   = 99_999_999,
    parameter int CNT_W       = 27
) (
    input  logic        clk_50m,
    input  logic        cr,
    input  logic        sig_in,
    input  logic        hold,
    output logic [31:0] freq_bcd,
    output logic        freq_valid,
    output logic        ovf,
    output logic        busy
);

    localparam int SH_W  = 32 + CNT_W;
    localparam int BIT_W = $clog2(CNT_W);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COUNT);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CNT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    // input synchronizer plus edge-detect flop
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_edge;

    // gate / edge counters
    logic [CNT_W-1:0] r_gcnt;
    logic [CNT_W-1:0] r_ecnt;
    logic             r_sat;
    logic             r_sat_l;
    logic             w_term;
    logic [CNT_W:0]   w_sum;
    logic             w_sum_sat;
    logic [CNT_W-1:0] w_close;

    // conversion
    state_t           r_state;
    logic [SH_W-1:0]  r_sh;
    logic [SH_W-1:0]  w_adj;
    logic [BIT_W-1:0] r_bit;

    // freq_valid, freq_bcd, ovf and busy are all registered
    logic [31:0] r_bcd;
    logic        r_valid;
    logic        r_ovf;
    logic        r_busy;

    // Two flops to resynchronize sig_in, a third to find its rising edge
    always_ff @(posedge clk_50m) begin
        if (cr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

    // The saturated sum serves both as the next edge count and, on the
    // terminal cycle, as the closing value, so an edge there lands in the old window
    assign w_term    = (r_gcnt == GATE_LAST);
    assign w_sum     = {1'b0, r_ecnt} + {{CNT_W{1'b0}}, w_edge};
    assign w_sum_sat = (w_sum >= {1'b0, MAX_C});
    assign w_close   = w_sum_sat ? MAX_C : w_sum[CNT_W-1:0];

    // Free-running gate window and saturating edge counter
    always_ff @(posedge clk_50m) begin
        if (cr) begin
            r_gcnt  <= '0;
            r_ecnt  <= '0;
            r_sat   <= 1'b0;
            r_sat_l <= 1'b0;
        end else begin
            r_gcnt <= w_term ? '0 : r_gcnt + CNT_W'(1);
            if (w_term) begin
                r_sat_l <= r_sat | w_sum_sat;
                r_ecnt  <= '0;
                r_sat   <= 1'b0;
            end else if (w_edge) begin
                r_ecnt <= w_close;
                if (w_sum_sat) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    assign w_adj[CNT_W-1:0] = r_sh[CNT_W-1:0];
    for (genvar gi = 0; gi < 8; gi++) begin : g_dabble
        logic [3:0] w_nib;
        assign w_nib = r_sh[CNT_W + 4*gi +: 4];
        assign w_adj[CNT_W + 4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    // Conversion FSM; the shift register is loaded straight from the closing
    // count so conversion starts the cycle after the terminal cycle
    always_ff @(posedge clk_50m) begin
        if (cr) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_term) begin
                        r_sh    <= {32'b0, w_close};
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_sh <= w_adj << 1;
                    if (r_bit == BIT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!hold) begin
                        r_bcd   <= r_sh[SH_W-1 -: 32];
                        r_ovf   <= r_sat_l;
                        r_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign freq_bcd   = r_bcd;
    assign freq_valid = r_valid;
    assign ovf        = r_ovf;
    assign busy       = r_busy;

endmodule
